// File: rtl/cdma_wgs_sync_fifo.sv
// 32x32 synchronous FIFO for CDMA weight-group-size records: registered input stage,
// two-port RAM with registered read, output register feeding rd_data directly.
module cdma_wgs_sync_fifo (
    input  logic        clk,
    input  logic        reset_,
    input  logic        wr_req,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_req,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    input  logic [31:0] pwrbus_ram_pd
);

    logic        wr_ready_r;
    logic        in_valid_r;
    logic [31:0] in_data_r;
    logic        busy_int_r;
    logic [5:0]  wr_count_r;
    logic [4:0]  wr_adr_r;
    logic        rd_pushing_r;
    logic        credit_r;
    logic [5:0]  rd_count_r;
    logic        rd_req_p_r;
    logic [4:0]  rd_adr_r;
    logic        rd_req_r;
    logic [31:0] ram_q_r;
    logic [31:0] rd_data_r;
    logic [31:0] mem_r [0:31];

    logic        accept_s;
    logic        hold_s;
    logic        reserving_s;
    logic [5:0]  wr_count_next_s;
    logic        busy_next_s;
    logic        busy_in_next_s;
    logic        rd_popping_s;
    logic [5:0]  rd_count_next_s;
    logic        ram_re_s;
    logic [4:0]  ram_ra_s;
    logic        rd_req_next_s;
    logic        gate_en_s;
    logic        ram_pd_unused_s;

    // RAM power-down bus only matters to a physical macro; fold it so it is consumed.
    assign ram_pd_unused_s = ^pwrbus_ram_pd;

    assign accept_s       = wr_req && wr_ready_r;
    assign hold_s         = in_valid_r && busy_int_r;
    assign reserving_s    = in_valid_r && !busy_int_r;
    assign busy_next_s    = (wr_count_next_s == 6'd32);
    assign busy_in_next_s = wr_req ? busy_next_s
                                   : (in_valid_r && busy_next_s && !reserving_s);
    assign rd_popping_s   = rd_req_p_r && !(rd_req_r && !rd_ready);
    assign ram_re_s       = (rd_count_next_s != 6'd0) && (!rd_req_p_r || rd_popping_s);
    assign ram_ra_s       = rd_popping_s ? (rd_adr_r + 5'd1) : rd_adr_r;
    assign rd_req_next_s  = rd_req_p_r || (rd_req_r && !rd_ready);

    // Clock-enable form of the master clock gate; every gated flop only changes under it.
    assign gate_en_s = reserving_s || credit_r || rd_popping_s || rd_pushing_r
                     || (rd_req_r && rd_ready) || (busy_int_r != busy_next_s);

    assign wr_ready = wr_ready_r;
    assign rd_req   = rd_req_r;
    assign rd_data  = rd_data_r;

    // Write-side occupancy: reserve adds, the delayed pop credit removes.
    always_comb begin
        wr_count_next_s = wr_count_r;
        if (reserving_s && !credit_r) begin
            wr_count_next_s = wr_count_r + 6'd1;
        end else if (!reserving_s && credit_r) begin
            wr_count_next_s = wr_count_r - 6'd1;
        end else begin
            wr_count_next_s = wr_count_r;
        end
    end

    // Read-side occupancy: delayed reserve adds, pop into the output register removes.
    always_comb begin
        rd_count_next_s = rd_count_r;
        if (rd_pushing_r && !rd_popping_s) begin
            rd_count_next_s = rd_count_r + 6'd1;
        end else if (!rd_pushing_r && rd_popping_s) begin
            rd_count_next_s = rd_count_r - 6'd1;
        end else begin
            rd_count_next_s = rd_count_r;
        end
    end

    // Input stage control and registered wr_ready.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ready_r <= 1'b1;
            in_valid_r <= 1'b0;
        end else begin
            wr_ready_r <= !busy_in_next_s;
            if (!hold_s) begin
                in_valid_r <= accept_s;
            end
        end
    end

    // Input stage data capture.
    always_ff @(posedge clk) begin
        if (accept_s && !hold_s) begin
            in_data_r <= wr_data;
        end
    end

    // Counts, pointers and valids behind the gate enable.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            busy_int_r   <= 1'b0;
            wr_count_r   <= 6'd0;
            wr_adr_r     <= 5'd0;
            rd_pushing_r <= 1'b0;
            credit_r     <= 1'b0;
            rd_count_r   <= 6'd0;
            rd_req_p_r   <= 1'b0;
            rd_adr_r     <= 5'd0;
            rd_req_r     <= 1'b0;
        end else if (gate_en_s) begin
            busy_int_r   <= busy_next_s;
            wr_count_r   <= wr_count_next_s;
            rd_pushing_r <= reserving_s;
            credit_r     <= rd_popping_s;
            rd_count_r   <= rd_count_next_s;
            rd_req_r     <= rd_req_next_s;
            if (reserving_s) begin
                wr_adr_r <= wr_adr_r + 5'd1;
            end
            if (rd_pushing_r || rd_popping_s) begin
                rd_req_p_r <= (rd_count_next_s != 6'd0);
            end
            if (rd_popping_s) begin
                rd_adr_r <= rd_adr_r + 5'd1;
            end
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (reserving_s) begin
            mem_r[wr_adr_r] <= in_data_r;
        end
    end

    // RAM registered read, then output register loaded on pop.
    always_ff @(posedge clk) begin
        if (ram_re_s) begin
            ram_q_r <= mem_r[ram_ra_s];
        end
        if (rd_popping_s) begin
            rd_data_r <= ram_q_r;
        end
    end

endmodule

// File: tb/tb_cdma_wgs_sync_fifo.sv
// Directed self-checking bench for cdma_wgs_sync_fifo with a queue scoreboard.
module tb_cdma_wgs_sync_fifo;

    logic        clk = 1'b0;
    logic        reset_;
    logic        wr_req;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_req;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic [31:0] pwrbus_ram_pd;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] exp_q [$];
    int          n_acc;
    int          n_con;
    int          first_con;
    int          last_con;
    logic        hold_prev;
    logic [31:0] prev_data;
    int          base;
    int          first_low;
    int          last_acc;

    always #5 clk = ~clk;

    cdma_wgs_sync_fifo dut (
        .clk           (clk),
        .reset_        (reset_),
        .wr_req        (wr_req),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_req        (rd_req),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        n_acc     = 0;
        n_con     = 0;
        first_con = -1;
        last_con  = -1;
        hold_prev = 1'b0;
        prev_data = 32'd0;
    endtask

    // Drive one cycle, score outputs against the queue model, advance.
    task automatic cycle_io(input logic wq, input logic [31:0] wd, input logic rr);
        logic [31:0] e;
        wr_req   = wq;
        wr_data  = wd;
        rd_ready = rr;
        if (hold_prev) begin
            check_value("hold_rd_req", {31'd0, rd_req}, 32'd1);
            check_value("hold_rd_data", rd_data, prev_data);
        end
        if (rd_req && rd_ready) begin
            check_value("rd_when_empty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_value("order", rd_data, e);
            end
            n_con++;
            if (first_con < 0) first_con = cyc;
            last_con = cyc;
        end
        if (wr_req && wr_ready) begin
            exp_q.push_back(wd);
            n_acc++;
        end
        hold_prev = rd_req && !rd_ready;
        prev_data = rd_data;
        step();
    endtask

    initial begin
        reset_        = 1'b0;
        wr_req        = 1'b0;
        wr_data       = 32'd0;
        rd_ready      = 1'b0;
        pwrbus_ram_pd = 32'd0;
        clear_sb();
        repeat (3) step();
        check_value("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check_value("rst_rd_req", {31'd0, rd_req}, 32'd0);
        reset_ = 1'b1;
        repeat (5) step();
        check_value("idle_rd_req", {31'd0, rd_req}, 32'd0);
        check_value("idle_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Single word latency
        wr_req   = 1'b1;
        wr_data  = 32'hDEADBEEF;
        rd_ready = 1'b1;
        check_value("sw_wr_ready", {31'd0, wr_ready}, 32'd1);
        step();
        wr_req  = 1'b0;
        wr_data = 32'd0;
        for (int i = 1; i <= 3; i++) begin
            check_value("sw_early_rd_req", {31'd0, rd_req}, 32'd0);
            step();
        end
        check_value("sw_c4_rd_req", {31'd0, rd_req}, 32'd1);
        check_value("sw_c4_rd_data", rd_data, 32'hDEADBEEF);
        step();
        check_value("sw_c5_rd_req", {31'd0, rd_req}, 32'd0);
        repeat (3) step();

        // Fill to capacity with the read side stalled
        clear_sb();
        base      = cyc;
        first_low = -1;
        last_acc  = -1;
        for (int i = 0; i < 45; i++) begin
            if (wr_ready) last_acc = cyc - base;
            if (!wr_ready && first_low < 0) first_low = cyc - base;
            cycle_io(1'b1, 32'(n_acc), 1'b0);
        end
        check_value("fill_accepts", 32'(n_acc), 32'd34);
        check_value("fill_last_accept_cycle", 32'(last_acc), 32'd33);
        check_value("fill_ready_low_cycle", 32'(first_low), 32'd34);
        check_value("fill_wr_ready", {31'd0, wr_ready}, 32'd0);
        check_value("fill_rd_req", {31'd0, rd_req}, 32'd1);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            cycle_io(1'b0, 32'd0, 1'b1);
        end
        check_value("drain_count", 32'(n_con), 32'd34);
        check_value("drain_back_to_back", 32'(last_con - first_con), 32'd33);
        repeat (4) cycle_io(1'b0, 32'd0, 1'b1);
        check_value("drain_wr_ready", {31'd0, wr_ready}, 32'd1);
        check_value("drain_rd_req", {31'd0, rd_req}, 32'd0);

        // Random backpressure on both sides
        clear_sb();
        for (int i = 0; i < 4000 && n_con < 200; i++) begin
            cycle_io((n_acc < 200) && ($urandom_range(0, 3) != 0), $urandom,
                     1'($urandom_range(0, 1)));
        end
        check_value("bp_accepts", 32'(n_acc), 32'd200);
        check_value("bp_consumed", 32'(n_con), 32'd200);
        repeat (6) cycle_io(1'b0, 32'd0, 1'b1);

        // Full-rate stream across pointer wrap
        clear_sb();
        base = cyc;
        for (int i = 0; i < 120; i++) begin
            cycle_io(n_acc < 100, 32'hA000_0000 + 32'(n_acc), 1'b1);
        end
        check_value("wrap_consumed", 32'(n_con), 32'd100);
        check_value("wrap_latency", 32'(first_con - base), 32'd4);
        check_value("wrap_throughput", 32'(last_con - first_con), 32'd99);

        // Reset with words queued
        clear_sb();
        for (int i = 0; i < 10; i++) cycle_io(1'b1, 32'h5000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 5; i++) cycle_io(1'b0, 32'd0, 1'b0);
        check_value("mr_queued_rd_req", {31'd0, rd_req}, 32'd1);
        reset_ = 1'b0;
        #1;
        check_value("mr_rd_req", {31'd0, rd_req}, 32'd0);
        check_value("mr_wr_ready", {31'd0, wr_ready}, 32'd1);
        step();
        reset_ = 1'b1;
        step();
        clear_sb();
        base = cyc;
        cycle_io(1'b1, 32'hCAFE0001, 1'b1);
        for (int i = 0; i < 8; i++) cycle_io(1'b0, 32'd0, 1'b1);
        check_value("mr_consumed", 32'(n_con), 32'd1);
        check_value("mr_latency", 32'(first_con - base), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdma_wgs_sync_fifo.md
Name: cdma_wgs_sync_fifo

Overview:
- Synchronous 32-entry x 32-bit FIFO for the CDMA weight path (weight-group-size records); single clock domain.
- Write side: valid/ready with one registered input stage. Storage: two-port 32x32 RAM with a registered read output.
- Read side: valid/ready; rd_data is driven directly from the RAM output register.
- Internal master clock gating for power; it has no functional visibility.

Parameters:
- DEPTH, 32, RAM entries (fixed; pointers 5 bits, counts 6 bits)
- WIDTH, 32, data width (fixed)

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous, active-low reset
- wr_req  in  1  write valid
- wr_ready  out  1  write ready; word accepted when wr_req && wr_ready
- wr_data  in  32  write data
- rd_req  out  1  read valid
- rd_ready  in  1  read ready; word consumed when rd_req && rd_ready
- rd_data  out  32  read data, valid while rd_req=1
- pwrbus_ram_pd  in  32  RAM power-down control; passed to storage, no functional effect

Behaviour:
- Reset state:
  - wr_ready=1, rd_req=0; rd_data is don't-care.
  - All counts and pointers = 0.
  - Input-stage valid and read-side valids = 0.
- Input stage:
  - On accept, register wr_data and set the input-valid bit.
  - wr_ready is a registered signal, equal to the inverse of input-stage busy.
  - Input-stage busy next cycle:
    - if wr_req=1: busy_next;
    - else: input_valid && busy_next && !reserving.
  - When input_valid && the internal busy flag are both set, hold the stage contents.
- Reserve/push:
  - reserving = input_valid && !busy_int.
  - In that cycle, write the RAM at wr_adr, then increment wr_adr (wraps 31->0).
- Write count (6-bit):
  - +1 on reserve; -1 on a pop credit.
  - The pop credit is rd_popping delayed 1 cycle. Simultaneous reserve and credit leaves the count unchanged.
  - busy_next = (next count == 32).
  - busy_int is the registered copy of busy_next.
  - No write-limit override.
- Read count (6-bit):
  - +1 on rd_pushing (reserve delayed 1 cycle); -1 on rd_popping.
  - rd_req_p is updated to (next count != 0) whenever a push or pop occurs.
- RAM read enable = (next read count != 0) && (!rd_req_p || rd_popping).
  - Read address = rd_popping ? rd_adr+1 : rd_adr.
  - rd_adr increments (wraps) on rd_popping.
- rd_popping = rd_req_p && !(rd_req && !rd_ready). It also enables the RAM output register, loading the next word into rd_data.
- rd_req register next = rd_req_p || (rd_req && !rd_ready).
- Output stability: while rd_req=1 && rd_ready=0, rd_data and rd_req are held.
- Latency (empty FIFO, word accepted in cycle 0):
  - RAM write in cycle 1;
  - RAM read in cycle 2;
  - output register loaded at the end of cycle 3;
  - rd_req=1 with the data in cycle 4.
- Ordering: strict FIFO order; no loss or duplication across pointer wrap.
- Capacity: with rd_ready held 0 and wr_req held 1 from empty:
  - exactly 34 words are accepted (32 in RAM, 1 in the output register, 1 in the input stage);
  - wr_ready is 0 from the cycle after the 34th accept.
  - Each subsequent consume re-opens wr_ready after the credit delay.
- Clock gating:
  - Count, pointer and valid flops may use a gated clock.
  - The gate enable is the OR of: reserving, pop credit, rd_popping, rd_pushing, (rd_req && rd_ready), and (busy_int != busy_next).
  - Outputs must be cycle-identical to an ungated implementation.
- Reset mid-operation: all state returns to the reset values immediately; RAM contents are ignored after reset.

Test Plan:
- Reset: assert reset_=0 -> wr_ready=1, rd_req=0; release with no traffic -> rd_req stays 0.
- Single word: accept 0xDEADBEEF in cycle 0 with rd_ready=1 -> rd_req=1, rd_data=0xDEADBEEF in cycle 4; rd_req=0 in cycle 5.
- Fill: rd_ready=0, wr_req=1 continuous, data = 0..N -> 34 accepts, then wr_ready=0. Then rd_ready=1 -> values 0..33 read in order, one per cycle, and wr_ready reasserts.
- Backpressure: toggle rd_ready randomly over 200 words -> rd_data stable while rd_req && !rd_ready; output sequence equals input sequence.
- Wrap: stream 100 words at full rate with rd_ready=1 -> in order, no gaps after the initial 4-cycle latency, throughput 1 word/cycle.
- Mid-run reset: reset_ pulsed low with 10 words queued -> rd_req=0 and wr_ready=1 immediately; the next written word is read back first.
